// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch front end for a small sequencing core. Streams addresses to
// a synchronous instruction ROM (data returns one edge after the address) and
// registers each returned 9-bit word onto the decode outputs as opcode/operand.
//
// Optional feature macro: INSTR_FETCH_HALT_DETECT_EN
//   defined   -> a registered func/done instruction (op=31, operand[1:0]=3)
//                stops fetching and parks the FSM in HALT.
//   undefined -> no halt detection; func/done is an ordinary instruction.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, start_pc   : begin fetching at start_pc (only from IDLE or HALT)
//   stall             : downstream busy; hold decode outputs and in-flight word
//   redirect_valid/pc : flush and refetch from redirect_pc (FETCH only)
//   imem_addr/data    : synchronous instruction ROM port
//   dec_valid/op/operand/pc : decoded instruction and its address
//   halted            : FSM is in HALT
//
// State | meaning
// IDLE  | after reset; no fetching until start
// FETCH | streaming addresses, registering returned words
// HALT  | stopped on func/done; waits for start
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic            dec_valid,
    output logic [4:0]      dec_op,
    output logic [3:0]      dec_operand,
    output logic [PC_W-1:0] dec_pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            dec_valid_q, dec_valid_d;
    logic [4:0]      dec_op_q, dec_op_d;
    logic [3:0]      dec_operand_q, dec_operand_d;
    logic [PC_W-1:0] dec_pc_q, dec_pc_d;
    logic            halt_hit;

`ifdef INSTR_FETCH_HALT_DETECT_EN
    assign halt_hit = (imem_data[8:4] == 5'd31) && (imem_data[1:0] == 2'd3);
`else
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        dec_valid_d      = dec_valid_q;
        dec_op_d         = dec_op_q;
        dec_operand_d    = dec_operand_q;
        dec_pc_d         = dec_pc_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d          = S_FETCH;
                    fetch_pc_d       = start_pc;
                    inflight_valid_d = 1'b0;
                    dec_valid_d      = 1'b0;
                end else if (state_q == S_HALT && !stall) begin
                    // the halting instruction is held until downstream takes it
                    dec_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    fetch_pc_d       = redirect_pc;
                    inflight_valid_d = 1'b0;
                    dec_valid_d      = 1'b0;
                end else if (!stall) begin
                    fetch_pc_d       = fetch_pc_q + 1'b1;
                    inflight_valid_d = 1'b1;
                    inflight_pc_d    = fetch_pc_q;
                    if (inflight_valid_q) begin
                        dec_op_d      = imem_data[8:4];
                        dec_operand_d = imem_data[3:0];
                        dec_pc_d      = inflight_pc_q;
                        dec_valid_d   = 1'b1;
                        if (halt_hit) begin
                            state_d          = S_HALT;
                            inflight_valid_d = 1'b0;
                        end
                    end else begin
                        // consumed word not replaced: bubble
                        dec_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            fetch_pc_q       <= '0;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            dec_valid_q      <= 1'b0;
            dec_op_q         <= '0;
            dec_operand_q    <= '0;
            dec_pc_q         <= '0;
        end else begin
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            dec_valid_q      <= dec_valid_d;
            dec_op_q         <= dec_op_d;
            dec_operand_q    <= dec_operand_d;
            dec_pc_q         <= dec_pc_d;
        end
    end

    // While stalled, re-present the in-flight address so the ROM output
    // keeps showing the word that has not been registered yet.
    assign imem_addr   = (state_q == S_FETCH && stall) ? inflight_pc_q : fetch_pc_q;
    assign dec_valid   = dec_valid_q;
    assign dec_op      = dec_op_q;
    assign dec_operand = dec_operand_q;
    assign dec_pc      = dec_pc_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] start_pc = '0;
    logic            stall = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data = '0;
    logic            dec_valid;
    logic [4:0]      dec_op;
    logic [3:0]      dec_operand;
    logic [PC_W-1:0] dec_pc;
    logic            halted;

    int checks = 0;
    int failures = 0;

    logic [8:0] rom [0:(1<<PC_W)-1];

    instr_fetch #(.PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data), .dec_valid(dec_valid),
        .dec_op(dec_op), .dec_operand(dec_operand), .dec_pc(dec_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // synchronous ROM model
    always @(posedge clk) imem_data <= rom[imem_addr];

    typedef struct {
        bit rst;
        bit st;
        int spc;
        bit stl;
        bit rd;
        int rpc;
        bit ev;
        int epc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit st, int spc, bit stl, bit rd, int rpc,
                                bit ev, int epc);
        vec_t v;
        v.rst = rst; v.st = st; v.spc = spc; v.stl = stl;
        v.rd = rd; v.rpc = rpc; v.ev = ev; v.epc = epc;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_dec(string name, int epc);
        logic [8:0] w;
        w = rom[epc];
        check({name, " dec_valid"}, int'(dec_valid), 1);
        check({name, " dec_pc"}, int'(dec_pc), epc);
        check({name, " dec_op"}, int'(dec_op), int'(w[8:4]));
        check({name, " dec_operand"}, int'(dec_operand), int'(w[3:0]));
    endtask

    task automatic step(bit st, int spc, bit stl, bit rd, int rpc);
        start = st;
        start_pc = spc[PC_W-1:0];
        stall = stl;
        redirect_valid = rd;
        redirect_pc = rpc[PC_W-1:0];
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks outputs clear without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst dec_valid", int'(dec_valid), 0);
        check("rst dec_op", int'(dec_op), 0);
        check("rst dec_operand", int'(dec_operand), 0);
        check("rst dec_pc", int'(dec_pc), 0);
        check("rst halted", int'(halted), 0);
        check("rst imem_addr", int'(imem_addr), 0);
        start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < (1 << PC_W); n++) rom[n] = {1'b0, n[7:0]};

        // sequence A: basic stream, start ignored while fetching, stall hold
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 'h200, 0, 0, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 0, 0, 1, 4);
        add(0, 0, 0, 0, 0, 0, 1, 5);
        add(0, 0, 0, 1, 0, 0, 1, 5);
        add(0, 0, 0, 1, 0, 0, 1, 5);
        add(0, 0, 0, 1, 0, 0, 1, 5);
        add(0, 0, 0, 0, 0, 0, 1, 6);
        add(0, 0, 0, 0, 0, 0, 1, 7);
        // sequence B: redirect, then redirect together with stall
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 1, 'h040, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 'h040);
        add(0, 0, 0, 0, 0, 0, 1, 'h041);
        add(0, 0, 0, 1, 1, 'h010, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 'h010);
        add(0, 0, 0, 0, 0, 0, 1, 'h011);
        // sequence C: address wrap
        add(1, 1, 'h3FE, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 'h3FE);
        add(0, 0, 0, 0, 0, 0, 1, 'h3FF);
        add(0, 0, 0, 0, 0, 0, 1, 'h000);
        add(0, 0, 0, 0, 0, 0, 1, 'h001);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].rst) do_reset();
            step(vecs[i].st, vecs[i].spc, vecs[i].stl, vecs[i].rd, vecs[i].rpc);
            if (vecs[i].ev) check_dec(nm, vecs[i].epc);
            else check({nm, " dec_valid"}, int'(dec_valid), 0);
            check({nm, " halted"}, int'(halted), 0);
        end

        // redirect and stall have no effect in IDLE
        do_reset();
        step(0, 0, 1, 1, 'h055);
        check("idle dec_valid", int'(dec_valid), 0);
        check("idle imem_addr", int'(imem_addr), 0);
        step(0, 0, 0, 0, 0);
        check("idle imem_addr2", int'(imem_addr), 0);
        check("idle dec_valid2", int'(dec_valid), 0);

        // func/done at address 7
        rom[7] = 9'h1F3;
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_dec("halt pc5", 5);
        step(0, 0, 0, 0, 0);
        check_dec("halt pc6", 6);
        step(0, 0, 0, 0, 0);
        check_dec("halt pc7", 7);
`ifdef INSTR_FETCH_HALT_DETECT_EN
        check("halt halted", int'(halted), 1);
        step(0, 0, 1, 0, 0);
        check_dec("halt hold", 7);
        check("halt halted2", int'(halted), 1);
        step(0, 0, 0, 0, 0);
        check("halt drop dec_valid", int'(dec_valid), 0);
        check("halt halted3", int'(halted), 1);
        check("halt imem_addr", int'(imem_addr), 9);
        step(0, 0, 0, 1, 'h055);
        check("halt ign dec_valid", int'(dec_valid), 0);
        check("halt ign halted", int'(halted), 1);
        check("halt ign imem_addr", int'(imem_addr), 9);
        step(1, 'h010, 0, 0, 0);
        check("resume halted", int'(halted), 0);
        check("resume dec_valid", int'(dec_valid), 0);
        step(0, 0, 0, 0, 0);
        check("resume dec_valid2", int'(dec_valid), 0);
        step(0, 0, 0, 0, 0);
        check_dec("resume pc10", 'h010);
        check("resume halted2", int'(halted), 0);
`else
        check("nohalt halted", int'(halted), 0);
        step(0, 0, 0, 0, 0);
        check_dec("nohalt pc8", 8);
        check("nohalt halted2", int'(halted), 0);
`endif

        // reset in the middle of streaming
        do_reset();
        step(0, 0, 0, 0, 0);
        check("post rst dec_valid", int'(dec_valid), 0);
        check("post rst imem_addr", int'(imem_addr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
